// File: rtl/tbl_sched_pkg.sv
// Shared constants and types for the table-select scheduler.
//   DEPTH : number of table entries
//   DW    : entry width
//   IW    : index width, clog2(DEPTH)
//   TW    : packed table width presented to the external selector
package tbl_sched_pkg;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned DW    = 20;
    localparam int unsigned IW    = $clog2(DEPTH);
    localparam int unsigned TW    = DEPTH * DW;

    typedef logic [DW-1:0] tbl_entry_t;

    // Response slot occupancy.
    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
//   clk_i     : clock
//   rst_ni    : synchronous active-low reset (requester 0 gets top priority)
//   req_i     : request vector
//   advance_i : commit the current grant; pointer moves to the winner
//   gnt_o     : one-hot grant (zero when no request)
//   gnt_id_o  : binary index of the granted requester
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N-1:0]         req_i,
    input  logic                 advance_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] gnt_id_o
);

    localparam int unsigned IDW = $clog2(N);

    // Last granted requester; the search starts one past it.
    logic [IDW-1:0] ptr_q;

    always_comb begin
        int unsigned cand;
        logic        found;
        gnt_o    = '0;
        gnt_id_o = '0;
        found    = 1'b0;
        cand     = 0;
        for (int unsigned off = 1; off <= N; off++) begin
            cand = (32'(ptr_q) + off) % N;
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_id_o    = IDW'(cand);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            // Pointing at the last requester makes requester 0 the first candidate.
            ptr_q <= IDW'(N - 1);
        end else if (advance_i) begin
            ptr_q <= gnt_id_o;
        end
    end

endmodule

// File: rtl/tbl_sel_sched.sv
// Lookup-table owner and scheduler for a shared, external indexed selector.
//   clk        : clock
//   rst_n      : synchronous active-low reset; clears table and response slot
//   wr_en/wr_idx/wr_data : config write port into the table
//   req_valid/req_idx    : NREQ lookup requesters (index i at [i*IW +: IW])
//   req_ready  : one-hot grant, transfer on valid & ready
//   sel_a      : index driven to the selector
//   sel_ins    : packed table driven to the selector (entry i at [i*DW +: DW])
//   sel_tbl    : selector result, combinational from sel_a/sel_ins
//   rsp_valid/rsp_id/rsp_data/rsp_ready : 1-deep registered response slot
module tbl_sel_sched
    import tbl_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [IW-1:0]           wr_idx,
    input  logic [DW-1:0]           wr_data,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*IW-1:0]      req_idx,
    output logic [NREQ-1:0]         req_ready,
    output logic [IW-1:0]           sel_a,
    output logic [TW-1:0]           sel_ins,
    input  logic [DW-1:0]           sel_tbl,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [DW-1:0]           rsp_data,
    input  logic                    rsp_ready
);

    localparam int unsigned IDW = $clog2(NREQ);

    tbl_entry_t      tbl_q [DEPTH];
    slot_state_e     state_q, state_d;
    tbl_entry_t      rsp_data_q, rsp_data_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [IW-1:0]   sel_a_q;

    logic            can_issue;
    logic            any_gnt;
    logic            idx_in_range;
    logic [NREQ-1:0] arb_req;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic [IW-1:0]   win_idx;

    // A new lookup may enter when the slot is empty or is being drained this cycle.
    assign can_issue = (state_q == StEmpty) || rsp_ready;
    // Masking requests (rather than grants) keeps the arbiter pointer still under
    // backpressure and during reset.
    assign arb_req   = (rst_n && can_issue) ? req_valid : '0;

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (arb_req),
        .advance_i (any_gnt),
        .gnt_o     (gnt),
        .gnt_id_o  (gnt_id)
    );

    assign any_gnt   = |gnt;
    assign req_ready = gnt;
    assign win_idx   = req_idx[32'(gnt_id) * IW +: IW];

    // Hold the last index when idle so the selector input does not toggle.
    assign sel_a = any_gnt ? win_idx : sel_a_q;

    generate
        if (DEPTH == (2 ** IW)) begin : g_full_range
            assign idx_in_range = 1'b1;
        end else begin : g_part_range
            assign idx_in_range = (32'(sel_a) < DEPTH);
        end
    endgenerate

    always_comb begin
        sel_ins = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            sel_ins[i*DW +: DW] = tbl_q[i];
        end
    end

    assign rsp_valid = (state_q == StFull);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

    // Slot FSM: a grant always fills; an accepted response with no grant empties.
    always_comb begin
        state_d    = state_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        if (any_gnt) begin
            state_d    = StFull;
            rsp_data_d = idx_in_range ? sel_tbl : '0;
            rsp_id_d   = gnt_id;
        end else if ((state_q == StFull) && rsp_ready) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
            sel_a_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            if (any_gnt) begin
                sel_a_q <= win_idx;
            end
            // Storage feeds sel_ins directly, so a same-cycle lookup sees the old value.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wr_en && (wr_idx == IW'(i))) begin
                    tbl_q[i] <= wr_data;
                end
            end
        end
    end

    // A requester left waiting must not change its index while still valid.
    for (genvar g = 0; g < NREQ; g++) begin : g_idx_stable
        a_idx_stable: assert property (@(posedge clk) disable iff (!rst_n)
            (req_valid[g] && !req_ready[g]) |=>
            (!req_valid[g] || $stable(req_idx[g*IW +: IW])));
    end

endmodule

// File: tb/tb_tbl_sel_sched.sv
// Scoreboard bench for tbl_sel_sched; the external selector is modelled by a part-select.
module tb_tbl_sel_sched;
    import tbl_sched_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    logic                clk;
    logic                rst_n;
    logic                wr_en;
    logic [IW-1:0]       wr_idx;
    logic [DW-1:0]       wr_data;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*IW-1:0]  req_idx;
    logic [NREQ-1:0]     req_ready;
    logic [IW-1:0]       sel_a;
    logic [TW-1:0]       sel_ins;
    logic [DW-1:0]       sel_tbl;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [DW-1:0]       rsp_data;
    logic                rsp_ready;

    tbl_sel_sched #(
        .NREQ (NREQ)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .req_valid (req_valid),
        .req_idx   (req_idx),
        .req_ready (req_ready),
        .sel_a     (sel_a),
        .sel_ins   (sel_ins),
        .sel_tbl   (sel_tbl),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready)
    );

    assign sel_tbl = sel_ins[32'(sel_a) * DW +: DW];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
    } exp_t;

    exp_t          sb_q[$];
    int            n_vec = 0;
    int            n_err = 0;

    logic [DW-1:0] m_tbl [DEPTH];
    int            m_ptr;
    bit            m_full;
    logic [IW-1:0] m_last_a;
    int            last_w;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, want, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_tbl[i] = '0;
        m_ptr    = NREQ - 1;
        m_full   = 1'b0;
        m_last_a = '0;
        sb_q.delete();
    endtask

    // One clock: compare at negedge against the model, advance the model at posedge.
    task automatic tick();
        int            w;
        int            c;
        logic [IW-1:0] widx;
        exp_t          e;
        w    = -1;
        widx = '0;
        @(negedge clk);
        if (!rst_n) begin
            check_val("rdy_rst", 32'(req_ready), 0);
        end else begin
            if (!m_full || rsp_ready) begin
                for (int k = 1; k <= NREQ; k++) begin
                    c = (m_ptr + k) % NREQ;
                    if (w < 0 && req_valid[c]) w = c;
                end
            end
            check_val("rdy", 32'(req_ready), (w < 0) ? 0 : (1 << w));
            check_val("rvld", 32'(rsp_valid), 32'(m_full));
            if (m_full && sb_q.size() > 0) begin
                e = sb_q[0];
                check_val("rsp_id", 32'(rsp_id), 32'(e.id));
                check_val("rsp_data", 32'(rsp_data), 32'(e.data));
                if (rsp_ready) void'(sb_q.pop_front());
            end
            if (w >= 0) begin
                widx = req_idx[w*IW +: IW];
                check_val("sel_a", 32'(sel_a), 32'(widx));
                e.id   = IDW'(w);
                e.data = m_tbl[widx];
                sb_q.push_back(e);
            end else begin
                check_val("sel_a_hold", 32'(sel_a), 32'(m_last_a));
            end
        end
        last_w = w;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (wr_en) m_tbl[wr_idx] = wr_data;
            if (w >= 0) begin
                m_ptr    = w;
                m_last_a = widx;
                m_full   = 1'b1;
            end else if (m_full && rsp_ready) begin
                m_full = 1'b0;
            end
        end
        #1;
    endtask

    task automatic write_entry(input int idx, input logic [DW-1:0] val);
        wr_en   = 1'b1;
        wr_idx  = IW'(idx);
        wr_data = val;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = '0;
        wr_data   = '0;
        req_valid = '0;
        req_idx   = '0;
        rsp_ready = 1'b0;
        last_w    = -1;
        model_reset();

        // Reset state
        tick();
        tick();
        rst_n = 1'b1;
        check_val("rst_rvld", 32'(rsp_valid), 0);
        check_val("rst_rid", 32'(rsp_id), 0);
        check_val("rst_rdata", 32'(rsp_data), 0);
        check_val("rst_tbl", 32'(|sel_ins), 0);

        // 1: write then single lookup
        write_entry(7, 20'hABCDE);
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        req_idx[0*IW +: IW] = 5'd7;
        tick();
        req_valid = '0;
        check_val("t1_vld", 32'(rsp_valid), 1);
        check_val("t1_id", 32'(rsp_id), 0);
        check_val("t1_data", 32'(rsp_data), 32'h000ABCDE);
        tick();

        // 2: all requesters, full throughput, from fresh priority
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) write_entry(i, DW'(32'h11111 * i));
        for (int i = 0; i < NREQ; i++) req_idx[i*IW +: IW] = IW'(i + 1);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check_val("t2_gnt", 32'(req_ready), 1 << (i % 4));
            tick();
            check_val("t2_rvld", 32'(rsp_valid), 1);
            check_val("t2_rid", 32'(rsp_id), i % 4);
        end

        // 3: backpressure holds the slot and blocks grants
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        req_idx[1*IW +: IW] = 5'd2;
        for (int i = 0; i < 3; i++) tick();
        check_val("t3_hold_id", 32'(rsp_id), 3);
        check_val("t3_hold_data", 32'(rsp_data), 32'h44444);
        rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        check_val("t3_rel_id", 32'(rsp_id), 1);
        check_val("t3_rel_data", 32'(rsp_data), 32'h22222);
        tick();

        // 4: same-cycle write and lookup returns the old entry
        write_entry(31, 20'h00001);
        wr_en   = 1'b1;
        wr_idx  = 5'd31;
        wr_data = 20'h12345;
        req_valid = 4'b0100;
        req_idx[2*IW +: IW] = 5'd31;
        tick();
        wr_en = 1'b0;
        check_val("t4_old", 32'(rsp_data), 32'h00001);
        tick();
        check_val("t4_new", 32'(rsp_data), 32'h12345);
        req_valid = '0;
        tick();

        // 5: reset while full discards the response and restores priority
        write_entry(7, 20'hABCDE);
        rsp_ready = 1'b0;
        req_valid = 4'b1000;
        req_idx[3*IW +: IW] = 5'd7;
        tick();
        check_val("t5_full", 32'(rsp_valid), 1);
        rst_n     = 1'b0;
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        check_val("t5_rvld", 32'(rsp_valid), 0);
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        req_idx   = '0;
        req_idx[0*IW +: IW] = 5'd7;
        #1;
        check_val("t5_prio", 32'(req_ready), 1);
        tick();
        req_valid = '0;
        check_val("t5_id", 32'(rsp_id), 0);
        check_val("t5_data", 32'(rsp_data), 0);
        tick();

        // 6: random traffic against the scoreboard
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!(req_valid[i] && last_w != i)) begin
                    req_valid[i] = ($urandom_range(0, 1) == 1);
                    req_idx[i*IW +: IW] = IW'($urandom_range(0, DEPTH - 1));
                end
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            wr_en     = ($urandom_range(0, 9) < 3);
            wr_idx    = IW'($urandom_range(0, DEPTH - 1));
            wr_data   = DW'($urandom);
            tick();
        end
        wr_en     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check_val("drain_rvld", 32'(rsp_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
